// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// datapath select codes and the decoded instruction class.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LUI   = 4'h2;
    localparam logic [3:0] OP_LW    = 4'h3;
    localparam logic [3:0] OP_SW    = 4'h4;
    localparam logic [3:0] OP_BEQ   = 4'h5;
    localparam logic [3:0] OP_JAL   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        IMM_SEXT12 = 2'd0,
        IMM_ZEXT   = 2'd1,
        IMM_UPPER  = 2'd2
    } imm_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ITYPE   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        imm_sel_e     imm;
    } decoded_t;

    // Classes whose second ALU operand is the extended immediate.
    function automatic logic uses_imm(instr_class_e cls);
        return (cls == CLS_ITYPE) || (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. Optional performance counter
// outputs appear only when CTRL_PERF_CNT_EN is defined.
interface multicycle_control_if #(
    parameter int OPC_W = 4
);
    logic             run;
    logic [OPC_W-1:0] opcode;
    logic             alu_zero;
    logic             mem_ready;

    logic [2:0]       state;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [1:0]       imm_sel;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             mem_req;
    logic             mem_we;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             halted;
    logic             fault;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0]      retired;
    logic [15:0]      stall_cycles;
`endif

    modport master (
        input  run, opcode, alu_zero, mem_ready,
        output state, ir_write, pc_write, pc_src, imm_sel, alu_src_b, alu_op,
               mem_req, mem_we, reg_write, wb_sel, halted, fault
`ifdef CTRL_PERF_CNT_EN
        , output retired, stall_cycles
`endif
    );

    modport slave (
        output run, opcode, alu_zero, mem_ready,
        input  state, ir_write, pc_write, pc_src, imm_sel, alu_src_b, alu_op,
               mem_req, mem_we, reg_write, wb_sel, halted, fault
`ifdef CTRL_PERF_CNT_EN
        , input retired, stall_cycles
`endif
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the IR opcode to an instruction class
// plus the immediate extension mode that class uses.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output decoded_t         dec
);

    always_comb begin
        // NOTE: every field is given a default before the case so no input
        // combination leaves it unassigned, which would otherwise infer a latch.
        dec.cls = CLS_ILLEGAL;
        dec.imm = IMM_SEXT12;
        case (opcode)
            OPC_W'(OP_RTYPE): dec.cls = CLS_RTYPE;
            OPC_W'(OP_ADDI):  dec.cls = CLS_ITYPE;
            OPC_W'(OP_LUI): begin
                dec.cls = CLS_ITYPE;
                dec.imm = IMM_UPPER;
            end
            OPC_W'(OP_LW):    dec.cls = CLS_LOAD;
            OPC_W'(OP_SW):    dec.cls = CLS_STORE;
            OPC_W'(OP_BEQ):   dec.cls = CLS_BRANCH;
            OPC_W'(OP_JAL):   dec.cls = CLS_JUMP;
            OPC_W'(OP_HALT):  dec.cls = CLS_HALT;
            default:          dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (fetch/decode/exec/mem/wb) with memory handshake,
// timeout and sticky fault. Define CTRL_PERF_CNT_EN for retired/stall counters.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    multicycle_control_if.master ctrl
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e           state_q;
    state_e           state_d;
    decoded_t         dec;
    decoded_t         dec_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             stalled;
    logic             timeout_hit;
    logic             illegal_hit;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode (ctrl.opcode),
        .dec    (dec)
    );

    assign stalled     = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !ctrl.mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && stalled
                         && ((int'(wait_cnt) + 1) >= MEM_TIMEOUT);
    assign illegal_hit = (state_q == ST_DECODE) && (dec.cls == CLS_ILLEGAL);

    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ctrl.run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (ctrl.mem_ready)  state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_DECODE: begin
                case (dec.cls)
                    CLS_HALT:    state_d = ST_HALT;
                    CLS_ILLEGAL: state_d = ST_FETCH;
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (dec_q.cls)
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                    CLS_BRANCH, CLS_JUMP: state_d = ST_FETCH;
                    default:              state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (ctrl.mem_ready)   state_d = (dec_q.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The instruction class is captured in DECODE so later states do not
    // depend on the opcode input staying put.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            dec_q    <= '0;
        end else begin
            if (stalled && (state_d == state_q)) wait_cnt <= wait_cnt + 1'b1;
            else                                 wait_cnt <= '0;
            if (illegal_hit || timeout_hit)      fault_q  <= 1'b1;
            if (state_q == ST_DECODE)            dec_q    <= dec;
        end
    end

    assign ctrl.state = state_q;
    assign ctrl.fault = fault_q;

    always_comb begin
        ctrl.ir_write  = 1'b0;
        ctrl.pc_write  = 1'b0;
        ctrl.pc_src    = PC_PLUS1;
        ctrl.imm_sel   = IMM_SEXT12;
        ctrl.alu_src_b = 1'b0;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_req   = 1'b0;
        ctrl.mem_we    = 1'b0;
        ctrl.reg_write = 1'b0;
        ctrl.wb_sel    = WB_ALU;
        ctrl.halted    = 1'b0;

        // Immediate operand selection is held from EXEC through MEM and WB.
        if ((state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)
            && uses_imm(dec_q.cls)) begin
            ctrl.imm_sel   = dec_q.imm;
            ctrl.alu_src_b = 1'b1;
        end

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (ctrl.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                case (dec_q.cls)
                    CLS_RTYPE: ctrl.alu_op = ALU_FUNCT;
                    CLS_BRANCH: begin
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.pc_write = ctrl.alu_zero;
                        ctrl.pc_src   = PC_BRANCH;
                    end
                    CLS_JUMP: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_sel    = WB_LINK;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_src    = PC_JUMP;
                    end
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = (dec_q.cls == CLS_STORE);
            end
            ST_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = (dec_q.cls == CLS_LOAD) ? WB_MEM : WB_ALU;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_q;
    logic [15:0] stall_q;
    logic        retire_evt;

    assign retire_evt = ((state_d == ST_FETCH) && (state_q inside {ST_EXEC, ST_MEM, ST_WB}))
                     || ((state_d == ST_HALT) && (state_q != ST_HALT));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire_evt) retired_q <= retired_q + 16'd1;
            if (stalled)    stall_q   <= stall_q + 16'd1;
        end
    end

    assign ctrl.retired      = retired_q;
    assign ctrl.stall_cycles = stall_q;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the 16-bit datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the immediate generator's extension-mode select, the ALU operand and operation selects, and the register-file and PC write enables.
- Handles the memory handshake.

Parameters:
- OPC_W, 4, opcode field width
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before raising fault (0 = never time out)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  synchronous active-low reset
- run  in  1  start request, sampled only in IDLE
- opcode  in  OPC_W  instruction opcode from IR, valid from DECODE onward
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- state  out  3  current FSM state encoding
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  0=PC+1, 1=branch target, 2=jump target
- imm_sel  out  2  0=sign-extend 12b, 1=zero-extend, 2=upper (imm<<4)
- alu_src_b  out  1  0=register, 1=immediate
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0=ALU, 1=memory, 2=PC+1 link
- halted  out  1  HALT state reached
- fault  out  1  sticky; illegal opcode or memory timeout

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (RST_N low at a CLK edge) has priority over everything, including mid-instruction and mid-handshake. It forces:
  - state to IDLE;
  - all outputs to 0;
  - the timeout counter to 0;
  - fault to 0.
- Opcodes:
  - 0 = R-type
  - 1 = ADDI
  - 2 = LUI
  - 3 = LW
  - 4 = SW
  - 5 = BEQ
  - 6 = JAL
  - F = HALT
  - Others are illegal.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: single cycle; decode the opcode.
  - HALT goes to HALT.
  - An illegal opcode sets fault and returns to FETCH (treated as NOP).
  - All other opcodes go to EXEC.
- EXEC:
  - R-type: alu_src_b=0, alu_op=2.
  - ADDI/LW/SW: imm_sel=0, alu_src_b=1, alu_op=0.
  - LUI: imm_sel=2, alu_src_b=1, alu_op=0.
  - BEQ: alu_op=1. pc_write=alu_zero, pc_src=1, then go to FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=2, then go to FETCH.
  - LW/SW go to MEM; R-type/ADDI/LUI go to WB.
  - imm_sel and alu_src_b hold their EXEC values through MEM and WB.
- MEM:
  - mem_req=1, mem_we=1 for SW.
  - When mem_ready=1: LW goes to WB, SW goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle, then go to FETCH.
  - wb_sel=1 for LW, 0 otherwise.
- Cycle counts with mem_ready=1 on first request (FETCH through last state):
  - R-type/ADDI/LUI: 4
  - LW: 5
  - SW: 4
  - BEQ/JAL: 3
- Handshake:
  - mem_req stays high, and mem_we stays stable, until the cycle mem_ready=1.
  - mem_ready outside FETCH/MEM is ignored.
- Timeout:
  - A counter increments each cycle in FETCH/MEM with mem_ready=0, and clears on state exit.
  - When the counter reaches MEM_TIMEOUT (nonzero), set fault and go to HALT.
- HALT: halted=1, all enables 0; only RST_N exits.
- fault is sticky until reset.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined:
  - adds outputs retired (16b) and stall_cycles (16b), both reset to 0;
  - retired increments on each transition back to FETCH from EXEC/MEM/WB, and on entry to HALT;
  - stall_cycles increments each FETCH/MEM cycle with mem_ready=0;
  - both wrap at 16'hFFFF -> 0.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - imm_sel, pc_src, wb_sel and alu_op codes.
- Sub-module ctrl_decode: combinational opcode -> instruction class (rtype, itype, load, store, branch, jump, halt, illegal), instantiated once.

Test Plan:
- Reset and run: RST_N=0 for 2 cycles, then run=1 with opcode=0 and mem_ready=1.
  -> state sequence 0,1,2,3,5,1.
  -> reg_write=1 only in WB, with wb_sel=0.
- LW with slow memory: mem_ready low for 3 cycles in MEM.
  -> mem_req held 4 cycles with mem_we=0.
  -> WB follows with wb_sel=1 and imm_sel=0.
- BEQ: run twice, once with alu_zero=1 and once with alu_zero=0.
  -> pc_write=1/pc_src=1 in EXEC, then pc_write=0 respectively.
  -> FETCH next in both cases.
- LUI and JAL:
  -> LUI gives imm_sel=2 in EXEC.
  -> JAL asserts reg_write, wb_sel=2, pc_write and pc_src=2 in the same EXEC cycle.
- Faults:
  - opcode=9 -> fault=1 and return to FETCH.
  - mem_ready held low 15 cycles in FETCH -> HALT, halted=1.
  - RST_N=0 mid-MEM -> IDLE, all outputs 0.
- CTRL_PERF_CNT_EN:
  - 3 R-type instructions then HALT -> retired=4.
  - 2 wait cycles -> stall_cycles=2.
